// File: rtl/ccip_polling_receiver.sv
// CCI-P c0 polling receiver: round-robin RDLINE_I polls over per-flow RPC rings,
// forwarding each cacheline whose toggle flag shows a fresh write.
package ccip_polling_pkg;
  localparam int LMAX_CCIP_BATCH = 2;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [31:0] rpc_id;
    logic [15:0] arg;
    logic [15:0] flags;
  } RpcIf;
endpackage

module ccip_polling_receiver
  import ccip_polling_pkg::*;
#(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int MAX_OUTSTANDING   = 8,
  parameter int UPDATE_BIT        = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
  input  t_ccip_clAddr                  rx_base_addr,
  input  logic [LMAX_CCIP_BATCH-1:0]    l_rx_batch_size,
  input  logic                          start,
  input  logic                          sRx_c0TxAlmFull,
  output t_if_ccip_c0_Tx                sTx_c0,
  input  t_if_ccip_c0_Rx                sRx_c0,
  output logic [$bits(RpcIf)-1:0]       rpc_out,
  output logic                          rpc_valid_out,
  output logic [LMAX_NUM_OF_FLOWS-1:0]  rpc_flow_id_out,
  output logic [31:0]                   polls_out,
  output logic [31:0]                   new_rpcs_out,
  output logic                          error
);

  localparam int MAX_RX_FLOWS = 2 ** LMAX_NUM_OF_FLOWS;
  localparam int OUT_W        = $clog2(MAX_OUTSTANDING + 1);
  localparam int RPC_W        = $bits(RpcIf);
  localparam int IDX_W        = LMAX_NUM_OF_FLOWS + 2;

  typedef enum logic {PollIdle, PollIssue} t_poll_state;

  t_poll_state                   state, state_next;
  logic [LMAX_NUM_OF_FLOWS-1:0]  flow_cnt;
  logic [1:0]                    slot_cnt;
  logic [OUT_W-1:0]              outstanding;
  logic [MAX_RX_FLOWS*4-1:0]     expected_flag;

  logic                          issue;
  logic [1:0]                    eff_lbatch;
  logic [1:0]                    slot_last;
  t_ccip_c0_ReqMemHdr            req_hdr;
  logic [IDX_W-1:0]              rsp_idx;
  logic                          rsp_accept;
  logic                          rsp_live;
  logic                          rsp_new;

  always_ff @(posedge clk) begin
    if (reset) state <= PollIdle;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      PollIdle: if (start) state_next = PollIssue;
      PollIssue: begin
        if (!start) state_next = PollIdle;
        else if (!sRx_c0TxAlmFull && outstanding < OUT_W'(MAX_OUTSTANDING)) issue = 1'b1;
      end
      default: state_next = PollIdle;
    endcase
  end

  always_comb begin
    eff_lbatch = (l_rx_batch_size > LMAX_CCIP_BATCH'(2)) ? 2'd2 : l_rx_batch_size;
    case (eff_lbatch)
      2'd0:    slot_last = 2'd0;
      2'd1:    slot_last = 2'd1;
      default: slot_last = 2'd3;
    endcase

    req_hdr          = '0;
    req_hdr.req_type = eREQ_RDLINE_I;
    req_hdr.vc_sel   = eVC_VH0;
    req_hdr.cl_len   = eCL_LEN_1;
    req_hdr.address  = rx_base_addr + (t_ccip_clAddr'(flow_cnt) << eff_lbatch)
                     + t_ccip_clAddr'(slot_cnt);
    req_hdr.mdata    = t_ccip_mdata'({flow_cnt, slot_cnt});

    rsp_idx    = sRx_c0.hdr.mdata[IDX_W-1:0];
    rsp_accept = sRx_c0.rspValid && (sRx_c0.hdr.resp_type == eRSP_RDLINE);
    // With nothing in flight the response cannot belong to us (e.g. issued before reset).
    rsp_live   = rsp_accept && (outstanding != '0);
    rsp_new    = rsp_live && (sRx_c0.data[UPDATE_BIT] == expected_flag[rsp_idx]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sTx_c0          <= '0;
      rpc_out         <= '0;
      rpc_valid_out   <= 1'b0;
      rpc_flow_id_out <= '0;
      polls_out       <= '0;
      new_rpcs_out    <= '0;
      error           <= 1'b0;
      flow_cnt        <= '0;
      slot_cnt        <= '0;
      outstanding     <= '0;
      expected_flag   <= '1;
    end else begin
      sTx_c0.valid <= issue;
      if (issue) begin
        sTx_c0.hdr <= req_hdr;
        polls_out  <= polls_out + 32'd1;
        if (slot_cnt == slot_last) begin
          slot_cnt <= '0;
          flow_cnt <= (flow_cnt == number_of_flows) ? '0 : flow_cnt + LMAX_NUM_OF_FLOWS'(1);
        end else begin
          slot_cnt <= slot_cnt + 2'd1;
        end
      end

      case ({issue, rsp_live})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (rsp_accept && outstanding == '0) error <= 1'b1;

      rpc_valid_out <= rsp_new;
      if (rsp_new) begin
        rpc_out                <= sRx_c0.data[RPC_W-1:0];
        rpc_flow_id_out        <= rsp_idx[IDX_W-1:2];
        expected_flag[rsp_idx] <= ~expected_flag[rsp_idx];
        new_rpcs_out           <= new_rpcs_out + 32'd1;
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{sRx_c0, 1'(NIC_ID)};

endmodule

// File: tb/tb_ccip_polling_receiver.sv
// Directed bench for ccip_polling_receiver: a ring-level reference model checked
// every cycle, plus literal expectations for the key poll/RPC scenarios.
module tb_ccip_polling_receiver;
  import ccip_polling_pkg::*;

  localparam int LF   = 1;
  localparam int NF   = 2 ** LF;
  localparam int MAXO = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [LF-1:0]          nf;
  t_ccip_clAddr           base;
  logic [1:0]             lb;
  logic                   start;
  logic                   alm;
  t_if_ccip_c0_Tx         tx;
  t_if_ccip_c0_Rx         rx;
  logic [63:0]            rpc_out;
  logic                   rpc_valid_out;
  logic [LF-1:0]          rpc_flow_id_out;
  logic [31:0]            polls_out;
  logic [31:0]            new_rpcs_out;
  logic                   error;

  ccip_polling_receiver #(
    .NIC_ID(0),
    .LMAX_NUM_OF_FLOWS(LF),
    .MAX_OUTSTANDING(MAXO),
    .UPDATE_BIT(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .number_of_flows(nf),
    .rx_base_addr(base),
    .l_rx_batch_size(lb),
    .start(start),
    .sRx_c0TxAlmFull(alm),
    .sTx_c0(tx),
    .sRx_c0(rx),
    .rpc_out(rpc_out),
    .rpc_valid_out(rpc_valid_out),
    .rpc_flow_id_out(rpc_flow_id_out),
    .polls_out(polls_out),
    .new_rpcs_out(new_rpcs_out),
    .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ring-level model: poll position, in-flight count, per-slot expected flags.
  int          m_out;
  bit          m_active;
  int          m_flow, m_slot;
  bit          m_flag [NF][4];
  logic [31:0] m_polls, m_rpcs;
  bit          m_err;

  bit          e_tx_valid, e_rpc_valid, e_zero, e_err;
  logic [63:0] e_addr, e_md, e_rpc, e_fid;
  logic [31:0] e_polls, e_rpcs;

  logic [41:0] addr_log [$];
  int          md_log [$];
  int          pend [$];
  logic [63:0] rpc_log [$];
  int          fid_log [$];

  initial begin : compare
    bit issue;
    int bsz, f, s, md;
    e_tx_valid = 0; e_rpc_valid = 0; e_zero = 1; e_err = 0;
    e_addr = '0; e_md = '0; e_rpc = '0; e_fid = '0; e_polls = '0; e_rpcs = '0;
    forever begin
      @(negedge clk);
      chk("tx_valid", 64'(tx.valid), 64'(e_tx_valid));
      if (e_tx_valid) begin
        chk("tx_addr", 64'(tx.hdr.address), e_addr);
        chk("tx_mdata", 64'(tx.hdr.mdata), e_md);
        chk("tx_req_type", 64'(tx.hdr.req_type), 64'(eREQ_RDLINE_I));
        chk("tx_vc_sel", 64'(tx.hdr.vc_sel), 64'(eVC_VH0));
        chk("tx_cl_len", 64'(tx.hdr.cl_len), 64'(eCL_LEN_1));
      end
      chk("rpc_valid", 64'(rpc_valid_out), 64'(e_rpc_valid));
      if (e_rpc_valid || e_zero) begin
        chk("rpc_out", rpc_out, e_zero ? 64'h0 : e_rpc);
        chk("rpc_flow_id", 64'(rpc_flow_id_out), e_zero ? 64'h0 : e_fid);
      end
      chk("polls_out", 64'(polls_out), 64'(e_polls));
      chk("new_rpcs_out", 64'(new_rpcs_out), 64'(e_rpcs));
      chk("error", 64'(error), 64'(e_err));

      if (tx.valid) begin
        addr_log.push_back(tx.hdr.address);
        md_log.push_back(int'(tx.hdr.mdata));
        pend.push_back(int'(tx.hdr.mdata));
      end
      if (rpc_valid_out) begin
        rpc_log.push_back(rpc_out);
        fid_log.push_back(int'(rpc_flow_id_out));
      end

      if (reset) begin
        m_out = 0; m_active = 0; m_flow = 0; m_slot = 0;
        m_polls = '0; m_rpcs = '0; m_err = 0;
        for (int i = 0; i < NF; i++) for (int j = 0; j < 4; j++) m_flag[i][j] = 1'b1;
        e_tx_valid = 0; e_rpc_valid = 0; e_zero = 1;
      end else begin
        e_zero = 0;
        bsz = 1 << ((lb > 2) ? 2 : int'(lb));
        issue = m_active && start && !alm && (m_out < MAXO);
        e_tx_valid = issue;
        if (issue) begin
          e_addr = 64'(base) + 64'(m_flow * bsz + m_slot);
          e_md = 64'(m_flow * 4 + m_slot);
          m_polls = m_polls + 32'd1;
          m_slot = (m_slot + 1) % bsz;
          if (m_slot == 0) m_flow = (m_flow == int'(nf)) ? 0 : m_flow + 1;
        end
        e_rpc_valid = 0;
        if (rx.rspValid && rx.hdr.resp_type == eRSP_RDLINE) begin
          if (m_out == 0) m_err = 1;
          else begin
            m_out--;
            md = int'(rx.hdr.mdata);
            f = md / 4;
            s = md % 4;
            if (rx.data[0] == m_flag[f][s]) begin
              e_rpc_valid = 1;
              e_rpc = rx.data[63:0];
              e_fid = 64'(f);
              m_flag[f][s] = ~m_flag[f][s];
              m_rpcs = m_rpcs + 32'd1;
            end
          end
        end
        if (issue) m_out++;
        m_active = start;
      end
      e_polls = m_polls;
      e_rpcs = m_rpcs;
      e_err = m_err;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic respond(input int md, input bit flag, input logic [63:0] payload);
    rx = '0;
    rx.rspValid = 1'b1;
    rx.hdr.resp_type = eRSP_RDLINE;
    rx.hdr.mdata = 16'(md);
    rx.data[63:0] = {payload[63:1], flag};
    for (int i = 0; i < pend.size(); i++)
      if (pend[i] == md) begin
        pend.delete(i);
        break;
      end
    cyc(1);
    rx = '0;
  endtask

  task automatic respond_stale(input int md);
    respond(md, ~m_flag[md / 4][md % 4], 64'h0);
  endtask

  task automatic advance_to(input logic [41:0] addr);
    for (int i = 0; i < 30; i++) begin
      if (addr_log.size() != 0 && addr_log[$] == addr) break;
      if (pend.size() != 0) respond_stale(pend[0]);
      cyc(3);
    end
    chk("reach_addr", (addr_log.size() != 0) ? 64'(addr_log[$]) : 64'hdead, 64'(addr));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [41:0] exp_addr [5];
    int exp_md [5];
    int p0, n0, saved [$];
    exp_addr = '{42'h1000, 42'h1001, 42'h1002, 42'h1003, 42'h1000};
    exp_md   = '{0, 1, 4, 5, 0};

    reset = 1'b1; start = 1'b0; alm = 1'b0; nf = 1'b1; lb = 2'd1;
    base = 42'h1000; rx = '0;
    cyc(3);
    reset = 1'b0;
    cyc(10);
    chk("idle_polls", 64'(polls_out), 64'd0);
    chk("idle_tx_valid", 64'(tx.valid), 64'd0);
    chk("idle_error", 64'(error), 64'd0);
    chk("idle_no_reqs", 64'(addr_log.size()), 64'd0);

    // Fill to the in-flight limit, then free one slot with a stale reply.
    start = 1'b1;
    cyc(12);
    chk("stall_polls", 64'(polls_out), 64'd4);
    chk("stall_reqs", 64'(addr_log.size()), 64'd4);
    respond(0, 1'b0, 64'h0);
    cyc(6);
    chk("one_more_polls", 64'(polls_out), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("seq_addr", (addr_log.size() > i) ? 64'(addr_log[i]) : 64'hdead, 64'(exp_addr[i]));
      chk("seq_mdata", (md_log.size() > i) ? 64'(md_log[i]) : 64'hdead, 64'(exp_md[i]));
    end
    chk("stale_no_rpc", 64'(rpc_log.size()), 64'd0);

    // Fresh line on flow 1 slot 0, then a repeat with the same flag, then a toggle.
    respond(4, 1'b1, 64'hABCD);
    cyc(2);
    chk("rpc1_count", 64'(rpc_log.size()), 64'd1);
    chk("rpc1_payload", (rpc_log.size() > 0) ? rpc_log[0] : 64'hdead, 64'hABCD);
    chk("rpc1_flow", (fid_log.size() > 0) ? 64'(fid_log[0]) : 64'hdead, 64'd1);
    chk("rpc1_new_rpcs", 64'(new_rpcs_out), 64'd1);
    advance_to(42'h1002);
    respond(4, 1'b1, 64'hABCD);
    cyc(3);
    chk("repeat_no_rpc", 64'(rpc_log.size()), 64'd1);
    chk("repeat_new_rpcs", 64'(new_rpcs_out), 64'd1);
    advance_to(42'h1002);
    respond(4, 1'b0, 64'h1234);
    cyc(3);
    chk("rpc2_count", 64'(rpc_log.size()), 64'd2);
    chk("rpc2_payload", (rpc_log.size() > 1) ? rpc_log[1] : 64'hdead, 64'h1234);
    chk("rpc2_flow", (fid_log.size() > 1) ? 64'(fid_log[1]) : 64'hdead, 64'd1);
    chk("rpc2_new_rpcs", 64'(new_rpcs_out), 64'd2);

    // Almost-full window right after 0x1001.
    advance_to(42'h1001);
    alm = 1'b1;
    p0 = int'(polls_out);
    n0 = addr_log.size();
    respond_stale(pend[0]);
    respond_stale(pend[0]);
    cyc(8);
    chk("almfull_polls", 64'(polls_out), 64'(p0));
    chk("almfull_reqs", 64'(addr_log.size()), 64'(n0));
    alm = 1'b0;
    cyc(5);
    chk("resume_addr", (addr_log.size() > n0) ? 64'(addr_log[n0]) : 64'hdead, 64'h1002);
    chk("resume_polls", 64'(polls_out), 64'(p0 + 2));

    // Issue and response together leave the in-flight count unchanged.
    alm = 1'b1;
    p0 = int'(polls_out);
    respond_stale(pend[0]);
    alm = 1'b0;
    respond_stale(pend[0]);
    cyc(8);
    chk("same_cycle_polls", 64'(polls_out), 64'(p0 + 2));

    // Reset with three reads in flight; their late responses are strays.
    alm = 1'b1;
    respond_stale(pend[0]);
    start = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    alm = 1'b0;
    saved = pend;
    pend.delete();
    chk("reset_inflight", 64'(saved.size()), 64'd3);
    chk("reset_polls", 64'(polls_out), 64'd0);
    foreach (saved[i]) begin
      respond(saved[i], 1'b1, 64'h55);
      if (i == 0) chk("stray_error", 64'(error), 64'd1);
    end
    cyc(3);
    chk("stray_no_rpc", 64'(rpc_log.size()), 64'd2);
    chk("stray_new_rpcs", 64'(new_rpcs_out), 64'd0);
    start = 1'b1;
    cyc(12);
    chk("post_reset_polls", 64'(polls_out), 64'd4);
    chk("error_sticky", 64'(error), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
